// File: rtl/sonic_tx_ctl_pkg.sv
// sonic_tx_ctl_pkg: shared widths for the SoNIC TX ring and 128->40 gearbox
package sonic_tx_ctl_pkg;
  localparam int TX_WRITE_ADDR_WIDTH = 9;
  localparam int TX_OWORD_BITS = 128;
  localparam int TX_WORD_BITS = 40;
  localparam int TX_ACC_BITS = 208;
  localparam int TX_CNT_BITS = 8;
  localparam logic [TX_CNT_BITS-1:0] TX_WORD_CNT = TX_CNT_BITS'(TX_WORD_BITS);
  localparam logic [TX_CNT_BITS-1:0] TX_OWORD_CNT = TX_CNT_BITS'(TX_OWORD_BITS);
  localparam logic [TX_CNT_BITS-1:0] TX_REFILL_CNT = TX_CNT_BITS'(2 * TX_WORD_BITS);
endpackage

// File: rtl/sonic_tx_gearbox_128_40.sv
// sonic_tx_gearbox_128_40: accumulates 128-bit owords and emits 40-bit words LSB first
module sonic_tx_gearbox_128_40
  import sonic_tx_ctl_pkg::*;
#(
  parameter logic [TX_WORD_BITS-1:0] IDLE_WORD = '0
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     land,
  input  logic [TX_OWORD_BITS-1:0] data_in,
  output logic                     need_more,
  output logic [TX_WORD_BITS-1:0]  tx_data,
  output logic                     tx_valid,
  output logic                     starve
);
  logic [TX_ACC_BITS-1:0] acc, acc_next;
  logic [TX_CNT_BITS-1:0] cnt, base, cnt_next;
  logic emit;
  // emit and land combine in one step: landing oword goes just above what survives the emit
  always_comb begin
    emit = !flush && cnt >= TX_WORD_CNT;
    base = emit ? cnt - TX_WORD_CNT : cnt;
    need_more = base < TX_REFILL_CNT;
    starve = !flush && cnt != '0 && cnt < TX_WORD_CNT;
    acc_next = (emit ? acc >> TX_WORD_BITS : acc)
             | (land ? {{(TX_ACC_BITS-TX_OWORD_BITS){1'b0}}, data_in} << base : '0);
    cnt_next = base + (land ? TX_OWORD_CNT : '0);
  end
  // accumulator and registered output; flush drops everything including a landing oword
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      tx_data <= IDLE_WORD;
      tx_valid <= 1'b0;
    end else if (flush) begin
      acc <= '0;
      cnt <= '0;
      tx_data <= IDLE_WORD;
      tx_valid <= 1'b0;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
      tx_data <= emit ? acc[TX_WORD_BITS-1:0] : IDLE_WORD;
      tx_valid <= emit;
    end
  end
endmodule

// File: rtl/sonic_tx_ctl.sv
// sonic_tx_ctl: TX ring fetch control feeding the 128->40 gearbox toward the transceiver
module sonic_tx_ctl
  import sonic_tx_ctl_pkg::*;
#(
  parameter int ADDR_WIDTH = TX_WRITE_ADDR_WIDTH,
  parameter logic [TX_WORD_BITS-1:0] IDLE_WORD = '0
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     wr_req,
  input  logic [ADDR_WIDTH-1:0]    wr_address_owords,
  input  logic [TX_OWORD_BITS-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]    tx_ring_wptr,
  input  logic                     enable_sfp,
  output logic [ADDR_WIDTH-1:0]    tx_ring_rptr,
  output logic [TX_WORD_BITS-1:0]  tx_data,
  output logic                     tx_valid,
  output logic                     tx_empty,
  output logic [31:0]              underrun_count
);
  logic [TX_OWORD_BITS-1:0] ring [2**ADDR_WIDTH];
  logic [TX_OWORD_BITS-1:0] rd_data;
  logic in_flight, need_more, starve, issue;
  assign tx_empty = tx_ring_rptr == tx_ring_wptr;
  assign issue = enable_sfp && !tx_empty && !in_flight && need_more;
  // ring storage: a read issued at the same edge as a write to that slot sees the old oword
  always_ff @(posedge clk_in) begin
    if (wr_req) ring[wr_address_owords] <= wr_data;
    if (issue) rd_data <= ring[tx_ring_rptr];
  end
  // fetch pointer and single outstanding read; disable rewinds the ring and drops the read
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tx_ring_rptr <= '0;
      in_flight <= 1'b0;
    end else begin
      tx_ring_rptr <= enable_sfp ? tx_ring_rptr + ADDR_WIDTH'(issue) : '0;
      in_flight <= issue;
    end
  end
  // saturating count of cycles where a partial word is stuck waiting for data
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) underrun_count <= '0;
    else if (starve && underrun_count != '1) underrun_count <= underrun_count + 32'd1;
  end
  sonic_tx_gearbox_128_40 #(.IDLE_WORD(IDLE_WORD)) u_gb (
    .clk_in   (clk_in),
    .reset    (reset),
    .flush    (!enable_sfp),
    .land     (in_flight),
    .data_in  (rd_data),
    .need_more(need_more),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .starve   (starve)
  );
endmodule

// File: tb/tb_sonic_tx_ctl.sv
// tb_sonic_tx_ctl: scoreboard bench for the TX ring controller
module tb_sonic_tx_ctl;
  localparam int AW = 9;
  logic clk_in = 1'b0;
  logic reset, wr_req, enable_sfp;
  logic [AW-1:0] wr_address_owords, tx_ring_wptr, tx_ring_rptr;
  logic [127:0] wr_data;
  logic [39:0] tx_data;
  logic tx_valid, tx_empty;
  logic [31:0] underrun_count;
  int n_tests = 0;
  int n_fail = 0;
  logic [127:0] ring_m [2**AW];
  bit bq[$];
  logic [39:0] exp_q[$];

  sonic_tx_ctl dut (
    .clk_in(clk_in), .reset(reset), .wr_req(wr_req), .wr_address_owords(wr_address_owords),
    .wr_data(wr_data), .tx_ring_wptr(tx_ring_wptr), .enable_sfp(enable_sfp),
    .tx_ring_rptr(tx_ring_rptr), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_empty(tx_empty), .underrun_count(underrun_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic write_oword(input int slot, input logic [127:0] d);
    wr_req = 1'b1;
    wr_address_owords = AW'(slot);
    wr_data = d;
    ring_m[slot] = d;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic model_push(input int slot);
    logic [39:0] w;
    for (int i = 0; i < 128; i++) bq.push_back(ring_m[slot][i]);
    while (bq.size() >= 40) begin
      for (int j = 0; j < 40; j++) w[j] = bq.pop_front();
      exp_q.push_back(w);
    end
  endtask

  task automatic flush_ring();
    enable_sfp = 1'b0;
    tx_ring_wptr = '0;
    tick();
    enable_sfp = 1'b1;
    bq.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    n_tests += 6;
    if (tx_ring_rptr !== '0) begin n_fail++; $display("FAIL reset_rptr: got %0d want 0", tx_ring_rptr); end
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    if (tx_data !== 40'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", tx_data); end
    if (tx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", tx_empty); end
    if (underrun_count !== 32'd0) begin n_fail++; $display("FAIL reset_underrun: got %0d want 0", underrun_count); end
    if (dut.u_gb.cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", dut.u_gb.cnt); end
  endtask

  task automatic test_five_owords();
    int seen = 0, last = -1, gaps = 0;
    logic [639:0] cat;
    enable_sfp = 1'b1;
    for (int s = 0; s < 5; s++) write_oword(s, rnd128());
    for (int s = 0; s < 5; s++) model_push(s);
    cat = {ring_m[4], ring_m[3], ring_m[2], ring_m[1], ring_m[0]};
    tx_ring_wptr = AW'(5);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (tx_valid) begin
        n_tests++;
        if (last >= 0 && c != last + 1) gaps++;
        last = c;
        if (tx_data !== cat[40*seen +: 40]) begin
          n_fail++; $display("FAIL five_word%0d: got %h want %h", seen, tx_data, cat[40*seen +: 40]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        seen++;
      end
    end
    n_tests += 6;
    if (seen != 16) begin n_fail++; $display("FAIL five_count: got %0d want 16", seen); end
    if (gaps != 0) begin n_fail++; $display("FAIL five_bubbles: got %0d want 0", gaps); end
    if (dut.u_gb.cnt !== 8'd0) begin n_fail++; $display("FAIL five_cnt: got %0d want 0", dut.u_gb.cnt); end
    if (underrun_count !== 32'd0) begin n_fail++; $display("FAIL five_underrun: got %0d want 0", underrun_count); end
    if (tx_ring_rptr !== AW'(5)) begin n_fail++; $display("FAIL five_rptr: got %0d want 5", tx_ring_rptr); end
    if (tx_empty !== 1'b1) begin n_fail++; $display("FAIL five_empty: got %b want 1", tx_empty); end
  endtask

  task automatic test_underrun();
    int seen = 0;
    logic [31:0] u0, u1;
    logic [127:0] a, b;
    logic [39:0] first, want;
    flush_ring();
    u0 = underrun_count;
    a = rnd128();
    b = rnd128();
    write_oword(0, a);
    model_push(0);
    tx_ring_wptr = AW'(1);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (tx_valid) begin
        n_tests++; seen++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL under_extra: got %h want none", tx_data); end
        else begin
          want = exp_q.pop_front();
          if (tx_data !== want) begin n_fail++; $display("FAIL under_word: got %h want %h", tx_data, want); end
        end
      end
    end
    u1 = underrun_count;
    repeat (10) tick();
    n_tests += 4;
    if (seen != 3) begin n_fail++; $display("FAIL under_count_words: got %0d want 3", seen); end
    if (dut.u_gb.cnt !== 8'd8) begin n_fail++; $display("FAIL under_leftover: got %0d want 8", dut.u_gb.cnt); end
    if (!(u1 > u0)) begin n_fail++; $display("FAIL under_started: got %0d want >%0d", u1, u0); end
    if (underrun_count !== u1 + 32'd10) begin n_fail++; $display("FAIL under_rate: got %0d want %0d", underrun_count, u1 + 32'd10); end
    write_oword(1, b);
    model_push(1);
    tx_ring_wptr = AW'(2);
    seen = 0;
    first = 'x;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (tx_valid) begin
        n_tests++;
        if (seen == 0) first = tx_data;
        seen++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL under_extra2: got %h want none", tx_data); end
        else begin
          want = exp_q.pop_front();
          if (tx_data !== want) begin n_fail++; $display("FAIL under_word2: got %h want %h", tx_data, want); end
        end
      end
    end
    n_tests++;
    if (first !== {b[31:0], a[127:120]}) begin
      n_fail++; $display("FAIL under_splice: got %h want %h", first, {b[31:0], a[127:120]});
    end
  endtask

  task automatic test_flush();
    int seen = 0, hit = 0, stray = 0;
    logic [39:0] want;
    flush_ring();
    for (int s = 0; s < 5; s++) write_oword(s, rnd128());
    for (int s = 0; s < 5; s++) model_push(s);
    tx_ring_wptr = AW'(5);
    for (int c = 0; c < 40 && !hit; c++) begin
      tick();
      if (tx_valid) begin
        n_tests++; seen++;
        want = exp_q.pop_front();
        if (tx_data !== want) begin n_fail++; $display("FAIL flush_word: got %h want %h", tx_data, want); end
        if (seen == 7) begin
          enable_sfp = 1'b0;
          tick();
          hit = 1;
        end
      end
    end
    n_tests += 4;
    if (!hit) begin n_fail++; $display("FAIL flush_reach7: got %0d words want 7", seen); end
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", tx_valid); end
    if (tx_ring_rptr !== '0) begin n_fail++; $display("FAIL flush_rptr: got %0d want 0", tx_ring_rptr); end
    if (dut.u_gb.cnt !== 8'd0) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", dut.u_gb.cnt); end
    bq.delete();
    exp_q.delete();
    tx_ring_wptr = '0;
    enable_sfp = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tx_valid) stray++;
    end
    n_tests += 2;
    if (stray != 0) begin n_fail++; $display("FAIL flush_reenable: got %0d words want 0", stray); end
    if (tx_ring_rptr !== '0) begin n_fail++; $display("FAIL flush_rptr_idle: got %0d want 0", tx_ring_rptr); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    logic [39:0] want;
    flush_ring();
    for (int s = 0; s < 5; s++) write_oword(s, rnd128());
    tx_ring_wptr = AW'(5);
    tick();
    reset = 1'b1;
    tx_ring_wptr = '0;
    #1;
    n_tests += 5;
    if (tx_ring_rptr !== '0) begin n_fail++; $display("FAIL rmid_rptr: got %0d want 0", tx_ring_rptr); end
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", tx_valid); end
    if (tx_data !== 40'h0) begin n_fail++; $display("FAIL rmid_data: got %h want 0", tx_data); end
    if (tx_empty !== 1'b1) begin n_fail++; $display("FAIL rmid_empty: got %b want 1", tx_empty); end
    if (underrun_count !== 32'd0) begin n_fail++; $display("FAIL rmid_underrun: got %0d want 0", underrun_count); end
    tick();
    reset = 1'b0;
    bq.delete();
    exp_q.delete();
    for (int s = 0; s < 5; s++) model_push(s);
    tx_ring_wptr = AW'(5);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (tx_valid) begin
        n_tests++; seen++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rmid_extra: got %h want none", tx_data); end
        else begin
          want = exp_q.pop_front();
          if (tx_data !== want) begin n_fail++; $display("FAIL rmid_word: got %h want %h", tx_data, want); end
        end
      end
    end
    n_tests += 2;
    if (seen != 16) begin n_fail++; $display("FAIL rmid_count: got %0d want 16", seen); end
    if (tx_ring_rptr !== AW'(5)) begin n_fail++; $display("FAIL rmid_rptr_end: got %0d want 5", tx_ring_rptr); end
  endtask

  task automatic test_read_during_write();
    int seen = 0;
    logic [39:0] want;
    logic [127:0] old3;
    flush_ring();
    for (int s = 0; s < 5; s++) write_oword(s, rnd128());
    old3 = ring_m[3];
    for (int s = 0; s < 3; s++) model_push(s);
    tx_ring_wptr = AW'(3);
    for (int c = 0; c < 30; c++) begin
      tick();
      if (tx_valid) begin
        n_tests++; seen++;
        want = exp_q.pop_front();
        if (tx_data !== want) begin n_fail++; $display("FAIL rdw_pre: got %h want %h", tx_data, want); end
      end
    end
    model_push(3);
    wr_req = 1'b1;
    wr_address_owords = AW'(3);
    wr_data = ~old3;
    ring_m[3] = ~old3;
    tx_ring_wptr = AW'(4);
    tick();
    wr_req = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (tx_valid) begin
        n_tests++; seen++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rdw_extra: got %h want none", tx_data); end
        else begin
          want = exp_q.pop_front();
          if (tx_data !== want) begin n_fail++; $display("FAIL rdw_old: got %h want %h", tx_data, want); end
        end
      end
    end
    n_tests++;
    if (seen != 12) begin n_fail++; $display("FAIL rdw_count: got %0d want 12", seen); end
  endtask

  task automatic test_wrap();
    int seen = 0, last = -1, gaps = 0, wrapped = 0;
    logic [AW-1:0] prev;
    logic [39:0] want;
    flush_ring();
    for (int s = 0; s < 508; s++) write_oword(s, rnd128());
    for (int s = 0; s < 508; s++) model_push(s);
    tx_ring_wptr = AW'(508);
    for (int c = 0; c < 1700; c++) begin
      tick();
      if (tx_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL wrap_fill_extra: got %h want none", tx_data); end
        else begin
          want = exp_q.pop_front();
          if (tx_data !== want) begin n_fail++; $display("FAIL wrap_fill: got %h want %h", tx_data, want); end
        end
      end
    end
    n_tests += 2;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_fill_left: got %0d pending want 0", exp_q.size()); end
    if (tx_ring_rptr !== AW'(508)) begin n_fail++; $display("FAIL wrap_pre_rptr: got %0d want 508", tx_ring_rptr); end
    for (int k = 0; k < 10; k++) write_oword((508 + k) % 512, rnd128());
    for (int k = 0; k < 10; k++) model_push((508 + k) % 512);
    prev = tx_ring_rptr;
    tx_ring_wptr = AW'(6);
    for (int c = 0; c < 60; c++) begin
      tick();
      if (prev == AW'(511) && tx_ring_rptr == '0) wrapped = 1;
      prev = tx_ring_rptr;
      if (tx_valid) begin
        n_tests++; seen++;
        if (last >= 0 && c != last + 1) gaps++;
        last = c;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL wrap_extra: got %h want none", tx_data); end
        else begin
          want = exp_q.pop_front();
          if (tx_data !== want) begin n_fail++; $display("FAIL wrap_word: got %h want %h", tx_data, want); end
        end
      end
    end
    n_tests += 4;
    if (seen != 32) begin n_fail++; $display("FAIL wrap_count: got %0d want 32", seen); end
    if (gaps != 0) begin n_fail++; $display("FAIL wrap_bubbles: got %0d want 0", gaps); end
    if (!wrapped) begin n_fail++; $display("FAIL wrap_511_to_0: got %0d want 1", wrapped); end
    if (tx_ring_rptr !== AW'(6)) begin n_fail++; $display("FAIL wrap_rptr_end: got %0d want 6", tx_ring_rptr); end
  endtask

  initial begin
    reset = 1'b1;
    wr_req = 1'b0;
    wr_address_owords = '0;
    wr_data = '0;
    tx_ring_wptr = '0;
    enable_sfp = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    test_reset();
    test_five_owords();
    test_underrun();
    test_flush();
    test_reset_mid();
    test_read_during_write();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
